datapath_bus_regs: RTL and testbench
====================================

Name: datapath_bus_regs

Overview:
- Datapath register bank and shared bus driven directly by the control state machine's strobes: bflag, reg_control, sel, per-register enables, aluop and finish.
- Holds PC, AR, IR, R, R1–R5, TR, TR2, TR4 and AC, plus the Z flag.
- Muxes one source onto the internal bus, loads or increments the enabled registers, and runs the AC ALU.
- Returns the opcode and Z to the controller and drives the IRAM/DRAM interface.

Parameters:
- DATA_W, 16, width of the data bus and of all general registers.
- ADDR_W, 16, width of PC and AR; must be ≤ DATA_W.
- OPC_W, 6, opcode field width returned to the controller.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- bflag  in  4  bus source select.
- reg_control  in  2  00 hold, 01 write (load from bus), 10 memory write, 11 increment.
- sel  in  2  memory select; 1 = IRAM, 2 = DRAM, others = none.
- pc, ar, ir, r, r1, r2, r3, r4, r5, tr, tr2, tr4, ac  in  1 each  register enables.
- aluop  in  3  AC operation select.
- finish  in  1  halt request.
- mem_rdata  in  DATA_W  read data from the selected memory.
- mem_addr  out  ADDR_W  equals AR.
- mem_wdata  out  DATA_W  equals the bus.
- iram_en, dram_en  out  1 each  decoded from sel.
- mem_we  out  1  write strobe.
- opcode  out  OPC_W  IR[DATA_W-1 -: OPC_W].
- z  out  1  zero flag.
- halted  out  1  sticky halt indicator.

Behaviour:
- Reset: when rst_n = 0 at a clk edge, all registers clear to 0, z = 1, halted = 0. Reset mid-operation is immediate at that edge and discards any in-flight update.
- Bus source, combinational from bflag:
  - 0 mem_rdata, 1 PC, 2 AR, 3 IR, 4 R, 5 R1, 6 R2, 7 R3, 8 R4, 9 R5, 10 TR, 11 TR2, 12 TR4, 13 AC, 14–15 all-zero.
  - PC and AR are zero-extended onto the bus. Loads into PC/AR take the bus LSBs.
- Register update, on each edge while halted = 0, for every register whose enable is 1:
  - reg_control 01: load from the bus. AC is the exception: it loads the ALU result.
  - reg_control 11: increment by 1, modulo 2^width (all-ones wraps to 0).
  - reg_control 00 or 10: hold.
  - Multiple enables in one cycle are legal; every enabled register performs the same operation.
- Memory write: mem_we = 1 only when reg_control = 10, halted = 0 and sel ∈ {1, 2}. It is combinational; the memory samples it on the same edge. No register changes in a memory-write cycle.
- Enables: iram_en = (sel = 1), dram_en = (sel = 2). Both are combinational and independent of halted.
- ALU, combinational, A = AC, B = bus:
  - 0 pass B, 1 A+B, 2 A−B, 3 A&B, 4 A|B, 5 A^B, 6 A<<1, 7 A>>1 (logical).
  - Result truncated to DATA_W; carry/borrow discarded.
- Z flag: z updates on any edge where AC changes by load or increment: z = 1 iff the new AC = 0. Otherwise z holds.
- Halt:
  - finish = 1 at an edge with halted = 0 sets halted = 1.
  - That edge's register update still completes.
  - Afterwards all registers, z and mem_we are frozen/0 until reset.
- Latency: bus and ALU paths are combinational. Register results are visible the cycle after the strobe. opcode and z follow their registers with no added delay.

Decomposition:
- Package datapath_pkg holds:
  - bus source codes BUS_MEM … BUS_AC, BUS_ZERO;
  - reg_control codes RC_HOLD, RC_WRITE, RC_MEMWR, RC_INC;
  - ALU codes ALU_PASS … ALU_SHR;
  - memory select codes SEL_IRAM, SEL_DRAM.
- One sub-module: dp_alu, a purely combinational A/B/op → result block.
- The bus mux and register bank stay in datapath_bus_regs.

Test Plan:
- Fetch sequence:
  - Cycle 1: bflag = 1, reg_control = 01, ar = 1, with PC = 0x0005 → AR = 0x0005, mem_addr = 0x0005.
  - Cycle 2: reg_control = 11, pc = 1 → PC = 0x0006.
  - Cycle 3: bflag = 0, reg_control = 01, ir = 1, mem_rdata = 0xA400 → IR = 0xA400, opcode = 6'h29.
- Increment wrap: AR = 0xFFFF, reg_control = 11, ar = 1 → AR = 0x0000; PC unchanged.
- ALU and Z:
  - AC = 0x0010, bflag = 4 with R = 0x0010, aluop = 2, ac = 1, reg_control = 01 → AC = 0x0000, z = 1.
  - Next, aluop = 1 with R = 0x0003 → AC = 0x0003, z = 0.
- Multi-load and memory write:
  - bflag = 13 with AC = 0x1234, r1 = r3 = tr = 1, reg_control = 01 → all three = 0x1234.
  - Then reg_control = 10, sel = 2 → mem_we = 1, dram_en = 1, mem_wdata = 0x1234, no register change.
  - With sel = 0 → mem_we = 0.
- Halt:
  - finish = 1 together with a PC increment → PC increments once, halted = 1.
  - Further strobes (load/inc/memwr) → no change, mem_we = 0.
- Reset mid-run: rst_n = 0 during an AC load → all registers 0, z = 1, halted = 0 at that edge. Release resumes normal loads.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared encodings for the datapath register bank: bus sources, register-control
// strobes, ALU operations and memory selects.
package datapath_pkg;

  typedef enum logic [3:0] {
    BUS_MEM  = 4'd0,
    BUS_PC   = 4'd1,
    BUS_AR   = 4'd2,
    BUS_IR   = 4'd3,
    BUS_R    = 4'd4,
    BUS_R1   = 4'd5,
    BUS_R2   = 4'd6,
    BUS_R3   = 4'd7,
    BUS_R4   = 4'd8,
    BUS_R5   = 4'd9,
    BUS_TR   = 4'd10,
    BUS_TR2  = 4'd11,
    BUS_TR4  = 4'd12,
    BUS_AC   = 4'd13,
    BUS_ZERO = 4'd14
  } bus_src_e;

  typedef enum logic [1:0] {
    RC_HOLD  = 2'd0,
    RC_WRITE = 2'd1,
    RC_MEMWR = 2'd2,
    RC_INC   = 2'd3
  } reg_ctrl_e;

  typedef enum logic [2:0] {
    ALU_PASS = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_OR   = 3'd4,
    ALU_XOR  = 3'd5,
    ALU_SHL  = 3'd6,
    ALU_SHR  = 3'd7
  } alu_op_e;

  localparam logic [1:0] SEL_IRAM = 2'd1;
  localparam logic [1:0] SEL_DRAM = 2'd2;

endpackage

// File: rtl/datapath_bus_regs_if.sv
// Controller/memory-facing signal bundle of the datapath: strobes in, memory
// interface and status out.
interface datapath_bus_regs_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned OPC_W  = 6
);
  logic [3:0]        bflag;
  logic [1:0]        reg_control;
  logic [1:0]        sel;
  logic              pc, ar, ir, r, r1, r2, r3, r4, r5, tr, tr2, tr4, ac;
  logic [2:0]        aluop;
  logic              finish;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              iram_en;
  logic              dram_en;
  logic              mem_we;
  logic [OPC_W-1:0]  opcode;
  logic              z;
  logic              halted;

  modport master (
    output bflag, reg_control, sel, pc, ar, ir, r, r1, r2, r3, r4, r5, tr, tr2, tr4, ac,
    output aluop, finish, mem_rdata,
    input  mem_addr, mem_wdata, iram_en, dram_en, mem_we, opcode, z, halted
  );

  modport slave (
    input  bflag, reg_control, sel, pc, ar, ir, r, r1, r2, r3, r4, r5, tr, tr2, tr4, ac,
    input  aluop, finish, mem_rdata,
    output mem_addr, mem_wdata, iram_en, dram_en, mem_we, opcode, z, halted
  );
endinterface

// File: rtl/dp_alu.sv
// Combinational accumulator ALU: A is AC, B is the internal bus; carries are dropped.
module dp_alu
  import datapath_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  alu_op_e           op_i,
  output logic [DATA_W-1:0] result_o
);

  always_comb begin
    result_o = '0;
    unique case (op_i)
      ALU_PASS: result_o = b_i;
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SHL:  result_o = a_i << 1;
      ALU_SHR:  result_o = a_i >> 1;
      default:  result_o = '0;
    endcase
  end

endmodule

// File: rtl/datapath_bus_regs.sv
// Datapath register bank, internal bus mux and AC ALU, driven directly by the
// controller's strobes.
module datapath_bus_regs
  import datapath_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned OPC_W  = 6
) (
  input logic                clk,
  input logic                rst_n,
  datapath_bus_regs_if.slave dp
);

  // Word-register slots (everything DATA_W wide except AC).
  localparam int unsigned NumWord = 10;
  localparam int unsigned WIr  = 0;
  localparam int unsigned WR   = 1;
  localparam int unsigned WR1  = 2;
  localparam int unsigned WR2  = 3;
  localparam int unsigned WR3  = 4;
  localparam int unsigned WR4  = 5;
  localparam int unsigned WR5  = 6;
  localparam int unsigned WTr  = 7;
  localparam int unsigned WTr2 = 8;
  localparam int unsigned WTr4 = 9;

  logic [ADDR_W-1:0]  pc_q, pc_d, ar_q, ar_d;
  logic [DATA_W-1:0]  word_q [NumWord];
  logic [DATA_W-1:0]  word_d [NumWord];
  logic [NumWord-1:0] word_en;
  logic [DATA_W-1:0]  ac_q, ac_d;
  logic               z_q, z_d;
  logic               halted_q, halted_d;

  logic [DATA_W-1:0]  pc_ext, ar_ext, bus_val, alu_res;
  logic               do_load, do_inc;

  always_comb begin
    pc_ext = '0;
    ar_ext = '0;
    pc_ext[ADDR_W-1:0] = pc_q;
    ar_ext[ADDR_W-1:0] = ar_q;
  end

  always_comb begin
    case (dp.bflag)
      BUS_MEM: bus_val = dp.mem_rdata;
      BUS_PC:  bus_val = pc_ext;
      BUS_AR:  bus_val = ar_ext;
      BUS_IR:  bus_val = word_q[WIr];
      BUS_R:   bus_val = word_q[WR];
      BUS_R1:  bus_val = word_q[WR1];
      BUS_R2:  bus_val = word_q[WR2];
      BUS_R3:  bus_val = word_q[WR3];
      BUS_R4:  bus_val = word_q[WR4];
      BUS_R5:  bus_val = word_q[WR5];
      BUS_TR:  bus_val = word_q[WTr];
      BUS_TR2: bus_val = word_q[WTr2];
      BUS_TR4: bus_val = word_q[WTr4];
      BUS_AC:  bus_val = ac_q;
      default: bus_val = '0;
    endcase
  end

  dp_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a_i      (ac_q),
    .b_i      (bus_val),
    .op_i     (alu_op_e'(dp.aluop)),
    .result_o (alu_res)
  );

  assign do_load = !halted_q && (dp.reg_control == RC_WRITE);
  assign do_inc  = !halted_q && (dp.reg_control == RC_INC);
  assign word_en = {dp.tr4, dp.tr2, dp.tr, dp.r5, dp.r4, dp.r3, dp.r2, dp.r1, dp.r, dp.ir};

  always_comb begin
    pc_d = pc_q;
    if (dp.pc) begin
      if (do_load)     pc_d = bus_val[ADDR_W-1:0];
      else if (do_inc) pc_d = pc_q + ADDR_W'(1);
    end

    ar_d = ar_q;
    if (dp.ar) begin
      if (do_load)     ar_d = bus_val[ADDR_W-1:0];
      else if (do_inc) ar_d = ar_q + ADDR_W'(1);
    end

    for (int i = 0; i < NumWord; i++) begin
      word_d[i] = word_q[i];
      if (word_en[i]) begin
        if (do_load)     word_d[i] = bus_val;
        else if (do_inc) word_d[i] = word_q[i] + DATA_W'(1);
      end
    end

    // AC loads from the ALU rather than straight off the bus.
    ac_d = ac_q;
    z_d  = z_q;
    if (dp.ac && (do_load || do_inc)) begin
      ac_d = do_load ? alu_res : ac_q + DATA_W'(1);
      z_d  = (ac_d == '0);
    end

    halted_d = halted_q | dp.finish;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q     <= '0;
      ar_q     <= '0;
      for (int i = 0; i < NumWord; i++) word_q[i] <= '0;
      ac_q     <= '0;
      z_q      <= 1'b1;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      ar_q     <= ar_d;
      for (int i = 0; i < NumWord; i++) word_q[i] <= word_d[i];
      ac_q     <= ac_d;
      z_q      <= z_d;
      halted_q <= halted_d;
    end
  end

  assign dp.mem_addr  = ar_q;
  assign dp.mem_wdata = bus_val;
  assign dp.iram_en   = (dp.sel == SEL_IRAM);
  assign dp.dram_en   = (dp.sel == SEL_DRAM);
  assign dp.mem_we    = !halted_q && (dp.reg_control == RC_MEMWR) &&
                        ((dp.sel == SEL_IRAM) || (dp.sel == SEL_DRAM));
  assign dp.opcode    = word_q[WIr][DATA_W-1 -: OPC_W];
  assign dp.z         = z_q;
  assign dp.halted    = halted_q;

endmodule

// File: tb/tb_datapath_bus_regs.sv
// Directed plus randomized bench for datapath_bus_regs against an array-based reference model.
module tb_datapath_bus_regs;

  // Enable bit positions; also the model array index (bus code minus one).
  localparam int E_PC = 0, E_AR = 1, E_IR = 2, E_R = 3, E_R1 = 4, E_R3 = 6, E_TR = 9, E_AC = 12;

  logic clk;
  logic rst_n;

  datapath_bus_regs_if #(.DATA_W(16), .ADDR_W(16), .OPC_W(6)) dp_if ();

  datapath_bus_regs #(
    .DATA_W (16),
    .ADDR_W (16),
    .OPC_W  (6)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dp    (dp_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [15:0] m_reg [13];
  logic        m_z;
  logic        m_halt;
  logic [15:0] last_wdata;
  logic        last_we, last_dram;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [15:0] m_bus(input logic [3:0] bf, input logic [15:0] rd);
    if (bf == 4'd0) return rd;
    if (bf <= 4'd13) return m_reg[bf - 4'd1];
    return 16'h0000;
  endfunction

  function automatic logic [15:0] m_alu(input logic [15:0] a, input logic [15:0] b,
                                        input logic [2:0] op);
    case (op)
      3'd0:    return b;
      3'd1:    return a + b;
      3'd2:    return a - b;
      3'd3:    return a & b;
      3'd4:    return a | b;
      3'd5:    return a ^ b;
      3'd6:    return {a[14:0], 1'b0};
      default: return {1'b0, a[15:1]};
    endcase
  endfunction

  // One clock: drive, check combinational outputs, clock, advance model, check state.
  task automatic step(input logic [3:0] bf, input logic [1:0] rc, input logic [1:0] sl,
                      input logic [12:0] en, input logic [2:0] op, input logic fin,
                      input logic [15:0] rd, input logic rn);
    logic [15:0] exp_b, alu_r;
    rst_n = rn;
    dp_if.bflag = bf;  dp_if.reg_control = rc;  dp_if.sel = sl;
    dp_if.aluop = op;  dp_if.finish = fin;      dp_if.mem_rdata = rd;
    dp_if.pc  = en[0];  dp_if.ar  = en[1];  dp_if.ir = en[2];  dp_if.r  = en[3];
    dp_if.r1  = en[4];  dp_if.r2  = en[5];  dp_if.r3 = en[6];  dp_if.r4 = en[7];
    dp_if.r5  = en[8];  dp_if.tr  = en[9];  dp_if.tr2 = en[10]; dp_if.tr4 = en[11];
    dp_if.ac  = en[12];
    #3;
    exp_b      = m_bus(bf, rd);
    last_wdata = dp_if.mem_wdata;
    last_we    = dp_if.mem_we;
    last_dram  = dp_if.dram_en;
    check_eq("mem_wdata", {16'h0, last_wdata}, {16'h0, exp_b});
    check_eq("mem_we", {31'h0, last_we},
             {31'h0, (rc == 2'd2) && !m_halt && (sl == 2'd1 || sl == 2'd2)});
    check_eq("iram_en", {31'h0, dp_if.iram_en}, {31'h0, sl == 2'd1});
    check_eq("dram_en", {31'h0, last_dram}, {31'h0, sl == 2'd2});
    @(posedge clk);
    if (!rn) begin
      for (int i = 0; i < 13; i++) m_reg[i] = 16'h0;
      m_z = 1'b1;
      m_halt = 1'b0;
    end else if (!m_halt) begin
      alu_r = m_alu(m_reg[12], exp_b, op);
      for (int i = 0; i < 13; i++) begin
        if (en[i]) begin
          if (rc == 2'd1)      m_reg[i] = (i == 12) ? alu_r : exp_b;
          else if (rc == 2'd3) m_reg[i] = m_reg[i] + 16'd1;
        end
      end
      if (en[12] && (rc == 2'd1 || rc == 2'd3)) m_z = (m_reg[12] == 16'h0);
      if (fin) m_halt = 1'b1;
    end
    #1;
    check_eq("mem_addr", {16'h0, dp_if.mem_addr}, {16'h0, m_reg[E_AR]});
    check_eq("opcode", {26'h0, dp_if.opcode}, {26'h0, m_reg[E_IR][15:10]});
    check_eq("z", {31'h0, dp_if.z}, {31'h0, m_z});
    check_eq("halted", {31'h0, dp_if.halted}, {31'h0, m_halt});
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] bf, input logic [15:0] exp);
    step(bf, 2'd0, 2'd0, 13'h0, 3'd0, 1'b0, 16'h0, 1'b1);
    check_eq(tag, {16'h0, last_wdata}, {16'h0, exp});
  endtask

  function automatic logic [12:0] en1(input int idx);
    logic [12:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  initial begin
    for (int i = 0; i < 13; i++) m_reg[i] = 16'h0;
    m_z = 1'b1;
    m_halt = 1'b0;
    @(posedge clk);
    #1;
    // Reset state
    step(4'd0, 2'd0, 2'd0, 13'h0, 3'd0, 1'b0, 16'h0, 1'b0);
    check_eq("rst_z", {31'h0, dp_if.z}, 32'd1);
    check_eq("rst_halted", {31'h0, dp_if.halted}, 32'd0);
    rd_chk("rst_pc", 4'd1, 16'h0000);
    rd_chk("rst_ac", 4'd13, 16'h0000);

    // Fetch sequence
    step(4'd0, 2'd1, 2'd0, en1(E_PC), 3'd0, 1'b0, 16'h0005, 1'b1);
    step(4'd1, 2'd1, 2'd0, en1(E_AR), 3'd0, 1'b0, 16'h0000, 1'b1);
    check_eq("fetch_addr", {16'h0, dp_if.mem_addr}, 32'h0005);
    step(4'd0, 2'd3, 2'd0, en1(E_PC), 3'd0, 1'b0, 16'h0000, 1'b1);
    rd_chk("fetch_pc", 4'd1, 16'h0006);
    step(4'd0, 2'd1, 2'd0, en1(E_IR), 3'd0, 1'b0, 16'hA400, 1'b1);
    check_eq("fetch_opcode", {26'h0, dp_if.opcode}, 32'h29);
    rd_chk("fetch_ir", 4'd3, 16'hA400);

    // Increment wrap
    step(4'd0, 2'd1, 2'd0, en1(E_AR), 3'd0, 1'b0, 16'hFFFF, 1'b1);
    step(4'd0, 2'd3, 2'd0, en1(E_AR), 3'd0, 1'b0, 16'h0000, 1'b1);
    check_eq("wrap_ar", {16'h0, dp_if.mem_addr}, 32'h0000);
    rd_chk("wrap_pc", 4'd1, 16'h0006);

    // ALU and Z
    step(4'd0, 2'd1, 2'd0, en1(E_AC), 3'd0, 1'b0, 16'h0010, 1'b1);
    step(4'd0, 2'd1, 2'd0, en1(E_R), 3'd0, 1'b0, 16'h0010, 1'b1);
    step(4'd4, 2'd1, 2'd0, en1(E_AC), 3'd2, 1'b0, 16'h0000, 1'b1);
    check_eq("sub_z", {31'h0, dp_if.z}, 32'd1);
    rd_chk("sub_ac", 4'd13, 16'h0000);
    step(4'd0, 2'd1, 2'd0, en1(E_R), 3'd0, 1'b0, 16'h0003, 1'b1);
    step(4'd4, 2'd1, 2'd0, en1(E_AC), 3'd1, 1'b0, 16'h0000, 1'b1);
    check_eq("add_z", {31'h0, dp_if.z}, 32'd0);
    rd_chk("add_ac", 4'd13, 16'h0003);

    // Multi-load and memory write
    step(4'd0, 2'd1, 2'd0, en1(E_AC), 3'd0, 1'b0, 16'h1234, 1'b1);
    step(4'd13, 2'd1, 2'd0, en1(E_R1) | en1(E_R3) | en1(E_TR), 3'd0, 1'b0, 16'h0, 1'b1);
    rd_chk("multi_r1", 4'd5, 16'h1234);
    rd_chk("multi_r3", 4'd7, 16'h1234);
    rd_chk("multi_tr", 4'd10, 16'h1234);
    step(4'd13, 2'd2, 2'd2, 13'h1FFF, 3'd0, 1'b0, 16'h0, 1'b1);
    check_eq("memwr_we", {31'h0, last_we}, 32'd1);
    check_eq("memwr_dram", {31'h0, last_dram}, 32'd1);
    check_eq("memwr_wdata", {16'h0, last_wdata}, 32'h1234);
    rd_chk("memwr_hold_r1", 4'd5, 16'h1234);
    step(4'd13, 2'd2, 2'd0, 13'h0, 3'd0, 1'b0, 16'h0, 1'b1);
    check_eq("memwr_nosel", {31'h0, last_we}, 32'd0);

    // Halt
    step(4'd0, 2'd3, 2'd0, en1(E_PC), 3'd0, 1'b1, 16'h0, 1'b1);
    check_eq("halt_flag", {31'h0, dp_if.halted}, 32'd1);
    rd_chk("halt_pc", 4'd1, 16'h0007);
    step(4'd0, 2'd1, 2'd0, 13'h1FFF, 3'd0, 1'b0, 16'hBEEF, 1'b1);
    step(4'd0, 2'd3, 2'd0, 13'h1FFF, 3'd0, 1'b0, 16'h0, 1'b1);
    step(4'd13, 2'd2, 2'd1, 13'h0, 3'd0, 1'b0, 16'h0, 1'b1);
    check_eq("halt_we", {31'h0, last_we}, 32'd0);
    rd_chk("halt_pc_frozen", 4'd1, 16'h0007);
    rd_chk("halt_ac_frozen", 4'd13, 16'h1234);

    // Reset mid-run during an AC load
    step(4'd0, 2'd1, 2'd0, en1(E_AC), 3'd0, 1'b0, 16'h0055, 1'b0);
    check_eq("mrst_z", {31'h0, dp_if.z}, 32'd1);
    check_eq("mrst_halted", {31'h0, dp_if.halted}, 32'd0);
    rd_chk("mrst_ac", 4'd13, 16'h0000);
    step(4'd0, 2'd1, 2'd0, en1(E_AC), 3'd0, 1'b0, 16'h0055, 1'b1);
    rd_chk("mrst_reload", 4'd13, 16'h0055);

    // Randomized traffic; occasional halt and reset keep both paths exercised.
    for (int n = 0; n < 400; n++) begin
      step(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           13'($urandom), 3'($urandom_range(0, 7)), ($urandom_range(0, 59) == 0),
           16'($urandom), ($urandom_range(0, 29) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
